// File: rtl/wb_regfile_hilo.sv
// MIPS write-back stage: selects the GPR write-back value and commits it into the 32x32 register file.
// It also updates HI/LO and serves the decode read ports with same-cycle write-through bypass.
module wb_regfile_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] wb_mult,
  input  logic [63:0] wb_div,
  input  logic [31:0] wb_clz,
  input  logic [31:0] wb_alu,
  input  logic [31:0] wb_dmem_odata,
  input  logic [31:0] wb_pc_plus4,
  input  logic [31:0] wb_rs_data,
  input  logic [31:0] wb_cp0_data,
  input  logic [31:0] wb_hi_data,
  input  logic [31:0] wb_lo_data,
  input  logic [4:0]  wb_regfiles_waddr,
  input  logic        wb_w_regfiles,
  input  logic        wb_w_hi,
  input  logic        wb_w_lo,
  input  logic [1:0]  wb_hi_choose,
  input  logic [1:0]  wb_lo_choose,
  input  logic [2:0]  wb_rd_choose,
  input  logic [4:0]  id_raddr1,
  input  logic [4:0]  id_raddr2,
  output logic [31:0] id_rdata1,
  output logic [31:0] id_rdata2,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata,
  output logic [31:0] wb_commit_cnt
);

  logic [31:0] gpr_r [32];
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] commit_cnt_r;
  logic [31:0] wd_s;
  logic [31:0] hi_next_s;
  logic [31:0] lo_next_s;
  logic        gpr_we_s;
  logic        hi_we_s;
  logic        lo_we_s;

  // GPR write-back source select
  always_comb begin
    wd_s = 32'd0;
    case (wb_rd_choose)
      3'd0:    wd_s = wb_alu;
      3'd1:    wd_s = wb_dmem_odata;
      3'd2:    wd_s = wb_pc_plus4;
      3'd3:    wd_s = wb_clz;
      3'd4:    wd_s = wb_cp0_data;
      3'd5:    wd_s = wb_hi_data;
      3'd6:    wd_s = wb_lo_data;
      3'd7:    wd_s = wb_mult[31:0];
      default: wd_s = 32'd0;
    endcase
  end

  // HI/LO source selects; select 3 is reserved and disqualifies the write
  always_comb begin
    hi_next_s = hi_r;
    lo_next_s = lo_r;
    case (wb_hi_choose)
      2'd0:    hi_next_s = wb_mult[63:32];
      2'd1:    hi_next_s = wb_div[63:32];
      2'd2:    hi_next_s = wb_rs_data;
      default: hi_next_s = hi_r;
    endcase
    case (wb_lo_choose)
      2'd0:    lo_next_s = wb_mult[31:0];
      2'd1:    lo_next_s = wb_div[31:0];
      2'd2:    lo_next_s = wb_rs_data;
      default: lo_next_s = lo_r;
    endcase
  end

  assign gpr_we_s = wb_w_regfiles && (wb_regfiles_waddr != 5'd0);
  assign hi_we_s  = wb_w_hi && (wb_hi_choose != 2'd3);
  assign lo_we_s  = wb_w_lo && (wb_lo_choose != 2'd3);

  // Decode read ports: r0 hardwired, then bypass of the pending write, then storage
  always_comb begin
    if (id_raddr1 == 5'd0) begin
      id_rdata1 = 32'd0;
    end else if (gpr_we_s && (id_raddr1 == wb_regfiles_waddr)) begin
      id_rdata1 = wd_s;
    end else begin
      id_rdata1 = gpr_r[id_raddr1];
    end
    if (id_raddr2 == 5'd0) begin
      id_rdata2 = 32'd0;
    end else if (gpr_we_s && (id_raddr2 == wb_regfiles_waddr)) begin
      id_rdata2 = wd_s;
    end else begin
      id_rdata2 = gpr_r[id_raddr2];
    end
  end

  assign hi_rdata      = hi_we_s ? hi_next_s : hi_r;
  assign lo_rdata      = lo_we_s ? lo_next_s : lo_r;
  assign wb_commit_cnt = commit_cnt_r;

  // Register file storage; entry 0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_r[i] <= 32'd0;
      end
    end else if (gpr_we_s) begin
      gpr_r[wb_regfiles_waddr] <= wd_s;
    end
  end

  // HI/LO update and commit counter; a reserved select still counts as a commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r         <= 32'd0;
      lo_r         <= 32'd0;
      commit_cnt_r <= 32'd0;
    end else begin
      if (hi_we_s) hi_r <= hi_next_s;
      if (lo_we_s) lo_r <= lo_next_s;
      if (wb_w_regfiles || wb_w_hi || wb_w_lo) commit_cnt_r <= commit_cnt_r + 32'd1;
    end
  end

endmodule
